// File: rtl/frame_buffer_writer_if.sv
// Camera-side pixel stream and frame-buffer write port of frame_buffer_writer.
// The writer takes the slave view; whoever drives the camera and consumes the writes takes the master view.
interface frame_buffer_writer_if;
  logic        start;
  logic        vsync;
  logic        href;
  logic        ready_color;
  logic [4:0]  red;
  logic [5:0]  green;
  logic [4:0]  blue;
  logic        we;
  logic [14:0] addr;
  logic [7:0]  data;
  logic        frame_done;
  logic        busy;
  logic        err;

  modport slave (
    input  start, vsync, href, ready_color, red, green, blue,
    output we, addr, data, frame_done, busy, err
  );

  modport master (
    output start, vsync, href, ready_color, red, green, blue,
    input  we, addr, data, frame_done, busy, err
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// Captures whole camera frames, decimates by DEC in both axes and writes RGB332 pixels
// to a frame buffer at sequential addresses; flags malformed frame geometry in a sticky ERR.
module frame_buffer_writer #(
  parameter int H_IN = 640,
  parameter int V_IN = 480,
  parameter int DEC  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  frame_buffer_writer_if.slave  port_io
);

  // One extra bit above what H_IN/V_IN need, so overlong lines/frames saturate instead of wrapping
  localparam int COL_W = $clog2(H_IN + 1) + 1;
  localparam int ROW_W = $clog2(V_IN + 1) + 1;
  localparam logic [COL_W-1:0] COL_MASK = COL_W'(DEC - 1);
  localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'(DEC - 1);
  localparam logic [COL_W-1:0] COL_END  = COL_W'(H_IN);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(V_IN);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2,
    DONE       = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             vsync_q, href_q, ready_q, start_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [14:0]      addr_cnt_q, addr_cnt_d;
  logic [14:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             we_q, we_d;
  logic             err_q, err_d;

  logic vsync_fall, vsync_rise, href_fall, ready_rise, start_rise;
  logic accept, on_grid, in_range;
  logic busy, frame_done;
  logic unused_bits;

  assign vsync_fall = vsync_q & ~port_io.vsync;
  assign vsync_rise = ~vsync_q & port_io.vsync;
  assign href_fall  = href_q & ~port_io.href;
  assign ready_rise = ~ready_q & port_io.ready_color;
  assign start_rise = ~start_q & port_io.start;

  assign accept   = (state_q == ACTIVE) && port_io.href && ready_rise;
  assign on_grid  = ((col_q & COL_MASK) == '0) && ((row_q & ROW_MASK) == '0);
  assign in_range = (col_q < COL_END) && (row_q < ROW_END);

  // Low colour bits are dropped by the RGB565 -> RGB332 reduction
  assign unused_bits = ^{port_io.red[1:0], port_io.green[2:0], port_io.blue[2:0]};

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_cnt_d = addr_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    err_d      = err_q;
    busy       = 1'b0;
    frame_done = 1'b0;

    if (start_rise) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (port_io.start) begin
          state_d = WAIT_FRAME;
        end
      end

      WAIT_FRAME: begin
        busy = 1'b1;
        if (!port_io.start) begin
          state_d = IDLE;
        end else if (vsync_fall) begin
          state_d    = ACTIVE;
          col_d      = '0;
          row_d      = '0;
          addr_cnt_d = '0;
        end
      end

      ACTIVE: begin
        busy = 1'b1;
        if (vsync_rise) begin
          state_d = DONE;
        end
        // A falling HREF with no pixels is a blanking glitch, not a line
        if (href_fall) begin
          col_d = '0;
          if (col_q != '0) begin
            row_d = (row_q == '1) ? row_q : row_q + 1'b1;
            if (col_q != COL_END) begin
              err_d = 1'b1;
            end
          end
        end
        if (accept) begin
          col_d = (col_q == '1) ? col_q : col_q + 1'b1;
          if (!in_range) begin
            err_d = 1'b1;
          end
          // Stored pixels arrive in raster order, so a running count equals the row-major address
          if (on_grid && in_range) begin
            we_d       = 1'b1;
            addr_d     = addr_cnt_q;
            addr_cnt_d = addr_cnt_q + 15'd1;
            data_d     = {port_io.red[4:2], port_io.green[5:3], port_io.blue[4:3]};
          end
        end
      end

      DONE: begin
        frame_done = 1'b1;
        state_d    = port_io.start ? WAIT_FRAME : IDLE;
        if (row_q != ROW_END) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      ready_q    <= 1'b0;
      start_q    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      addr_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= port_io.vsync;
      href_q     <= port_io.href;
      ready_q    <= port_io.ready_color;
      start_q    <= port_io.start;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_cnt_q <= addr_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  assign port_io.we         = we_q;
  assign port_io.addr       = addr_q;
  assign port_io.data       = data_q;
  assign port_io.err        = err_q;
  assign port_io.busy       = busy;
  assign port_io.frame_done = frame_done;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench for frame_buffer_writer on a reduced 32x16 camera frame, decimation 4.
module tb_frame_buffer_writer;
  localparam int H = 32;
  localparam int V = 16;
  localparam int D = 4;
  localparam int STORED = (H / D) * (V / D);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_buffer_writer_if bus ();

  frame_buffer_writer #(.H_IN(H), .V_IN(V), .DEC(D)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .port_io (bus)
  );

  typedef struct {
    int          cyc;
    logic [14:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int we_cnt = 0;
  int fd_cnt = 0;
  bit cap = 1'b0;
  int m_col = 0;
  int m_row = 0;
  bit first_pending = 1'b0;
  logic [14:0] first_addr = '0;
  logic [7:0]  first_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.frame_done) fd_cnt++;
    if (bus.we) begin
      we_cnt++;
      if (first_pending) begin
        first_addr = bus.addr;
        first_data = bus.data;
        first_pending = 1'b0;
      end
      chk("we_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("we_cycle", cyc, e.cyc);
        chk("we_addr", bus.addr, e.addr);
        chk("we_data", bus.data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b, input int hold);
    bus.red = r;
    bus.green = g;
    bus.blue = b;
    bus.ready_color = 1'b1;
    if (cap) begin
      if ((m_col % D) == 0 && (m_row % D) == 0 && m_col < H && m_row < V)
        sb.push_back('{cyc + 1, 15'((m_row / D) * (H / D) + m_col / D), {r[4:2], g[5:3], b[4:3]}});
      m_col++;
    end
    repeat (hold) tick();
    bus.ready_color = 1'b0;
    tick();
  endtask

  task automatic line(input int n, input int hold_first, input bit fix_first, input bit raise_start);
    bus.href = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      if (raise_start && i == 3) bus.start = 1'b1;
      if (i == 0 && fix_first) pixel(5'h1F, 6'h00, 5'h1F, hold_first);
      else pixel(5'($urandom), 6'($urandom), 5'($urandom), (i == 0) ? hold_first : 1);
    end
    bus.href = 1'b0;
    tick();
    if (cap) begin
      if (m_col > 0) m_row++;
      m_col = 0;
    end
    tick();
    tick();
  endtask

  task automatic frame(input bit cap_exp, input int short_row, input int rst_row,
                       input int start_row, input bit fix_first, input int hold_first);
    int fd0;
    bit aborted;
    fd0 = fd_cnt;
    aborted = 1'b0;
    bus.vsync = 1'b0;
    tick();
    cap = cap_exp;
    m_col = 0;
    m_row = 0;
    tick();
    for (int r = 0; r < V; r++) begin
      if (r == rst_row) begin
        rst_n = 1'b0;
        #2;
        chk("rst_mid_we", bus.we, 0);
        chk("rst_mid_addr", bus.addr, 0);
        chk("rst_mid_data", bus.data, 0);
        chk("rst_mid_frame_done", bus.frame_done, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_err", bus.err, 0);
        chk("rst_mid_sb_empty", sb.size(), 0);
        tick();
        rst_n = 1'b1;
        tick();
        cap = 1'b0;
        aborted = 1'b1;
      end
      if (r == short_row) chk("err_before_short", bus.err, 0);
      line((r == short_row) ? 24 : H, (r == 0) ? hold_first : 1, fix_first && r == 0, r == start_row);
      if (r == short_row) chk("err_after_short", bus.err, 1);
    end
    bus.vsync = 1'b1;
    tick();
    repeat (4) tick();
    cap = 1'b0;
    chk("frame_done_cnt", fd_cnt - fd0, (cap_exp && !aborted) ? 1 : 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int w0;
    bus.start = 1'b0;
    bus.vsync = 1'b1;
    bus.href = 1'b0;
    bus.ready_color = 1'b0;
    bus.red = '0;
    bus.green = '0;
    bus.blue = '0;
    repeat (3) tick();
    chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);

    rst_n = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    tick();
    chk("busy_armed", bus.busy, 1);

    // nominal frame
    w0 = we_cnt;
    first_pending = 1'b1;
    frame(1'b1, -1, -1, -1, 1'b0, 1);
    chk("nominal_we_cnt", we_cnt - w0, STORED);
    chk("nominal_first_addr", first_addr, 0);
    chk("nominal_err", bus.err, 0);

    // start raised mid-frame: no capture this frame
    bus.start = 1'b0;
    tick();
    tick();
    chk("busy_idle", bus.busy, 0);
    w0 = we_cnt;
    frame(1'b0, -1, -1, 2, 1'b0, 1);
    chk("midstart_we_cnt", we_cnt - w0, 0);
    chk("midstart_busy", bus.busy, 1);

    // encoding of the first pixel
    first_pending = 1'b1;
    frame(1'b1, -1, -1, -1, 1'b1, 1);
    chk("enc_addr", first_addr, 0);
    chk("enc_data", first_data, 8'hE3);

    // short line on row 3
    frame(1'b1, 3, -1, -1, 1'b0, 1);
    chk("err_sticky_after_frame", bus.err, 1);
    bus.start = 1'b0;
    tick();
    tick();
    chk("err_sticky_start_low", bus.err, 1);
    bus.start = 1'b1;
    tick();
    tick();
    chk("err_cleared_on_start", bus.err, 0);

    // READY_COLOR held high for 10 cycles on the first pixel
    w0 = we_cnt;
    frame(1'b1, -1, -1, -1, 1'b0, 10);
    chk("held_we_cnt", we_cnt - w0, STORED);

    // reset at row 8, then a clean frame from address 0
    frame(1'b1, -1, 8, -1, 1'b0, 1);
    w0 = we_cnt;
    first_pending = 1'b1;
    frame(1'b1, -1, -1, -1, 1'b0, 1);
    chk("post_rst_we_cnt", we_cnt - w0, STORED);
    chk("post_rst_first_addr", first_addr, 0);
    chk("post_rst_err", bus.err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/frame_buffer_writer.md
FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

Interface
REQ-001 The block SHALL have parameter H_IN, default 640, meaning active pixels per camera line.
REQ-002 The block SHALL have parameter V_IN, default 480, meaning active lines per camera frame.
REQ-003 The block SHALL have parameter DEC, default 4, meaning decimation factor in both axes (power of two).
REQ-004 The block SHALL have port CLK  in  1  system clock; one clock, all logic on its rising edge.
REQ-005 The block SHALL have port RST_N  in  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port START  in  1  level; high enables frame capture.
REQ-007 The block SHALL have port VSYNC  in  1  camera frame sync, already registered to CLK, high between frames.
REQ-008 The block SHALL have port HREF  in  1  camera line valid, already registered to CLK.
REQ-009 The block SHALL have port READY_COLOR  in  1  pixel-valid level from the colour capture stage; a new pixel is signalled by its 0->1 edge.
REQ-010 The block SHALL have ports RED, GREEN, BLUE  in  5, 6, 5  RGB565 pixel, stable while READY_COLOR high.
REQ-011 The block SHALL have port WE  out  1  frame-buffer write enable, one-cycle pulse per stored pixel.
REQ-012 The block SHALL have port ADDR  out  15  frame-buffer write address, range 0..(H_IN/DEC)*(V_IN/DEC)-1.
REQ-013 The block SHALL have port DATA  out  8  stored pixel, RGB332.
REQ-014 The block SHALL have port FRAME_DONE  out  1  one-cycle pulse at end of each captured frame.
REQ-015 The block SHALL have port BUSY  out  1  high while in WAIT_FRAME or ACTIVE.
REQ-016 The block SHALL have port ERR  out  1  sticky geometry error flag.

Function
REQ-017 The block SHALL implement the states IDLE, WAIT_FRAME, ACTIVE and DONE.
REQ-018 IDLE SHALL go to WAIT_FRAME when START=1.
REQ-019 WAIT_FRAME SHALL go to ACTIVE on a VSYNC 1->0 edge; a capture SHALL never begin mid-frame.
REQ-020 ACTIVE SHALL go to DONE on a VSYNC 0->1 edge.
REQ-021 DONE SHALL last exactly one cycle, then go to WAIT_FRAME if START=1, else to IDLE.
REQ-022 START falling in WAIT_FRAME SHALL return the block to IDLE; START falling in ACTIVE SHALL NOT abort the frame in progress.
REQ-023 Column counter col: cleared on entry to ACTIVE and on every HREF 1->0 edge; incremented by one per accepted pixel.
REQ-024 Row counter row: cleared on entry to ACTIVE; incremented on every HREF 1->0 edge when col>0.
REQ-025 A pixel SHALL be accepted only in ACTIVE, with HREF=1, on the cycle the READY_COLOR 0->1 edge is detected.
REQ-026 An accepted pixel SHALL be stored only when col%DEC==0, row%DEC==0, col<H_IN and row<V_IN.
REQ-027 Stored pixel timing: WE=1 for exactly one cycle, on the cycle after acceptance.
REQ-028 Stored pixel encoding: DATA={RED[4:2],GREEN[5:3],BLUE[4:3]}, registered at acceptance.
REQ-029 ADDR SHALL be (row/DEC)*(H_IN/DEC)+(col/DEC), produced by an incrementing counter, not a multiplier.
REQ-030 The ADDR counter SHALL be cleared on entry to ACTIVE and SHALL never wrap within a frame.
REQ-031 ERR SHALL be set on an HREF 1->0 edge with col!=H_IN and col>0.
REQ-032 ERR SHALL be set by any accepted pixel with col>=H_IN or row>=V_IN.
REQ-033 ERR SHALL be set in DONE if row!=V_IN.
REQ-034 ERR SHALL be cleared only on the START 0->1 edge, or by reset.
REQ-035 FRAME_DONE SHALL equal 1 exactly in the DONE cycle.
REQ-036 A WE due in the same cycle as the VSYNC 0->1 edge SHALL still be issued.
REQ-037 Pixels SHALL NOT be accepted after ACTIVE is left.
REQ-038 READY_COLOR remaining high SHALL yield only one pixel; a new pixel requires READY_COLOR to return to 0.

Reset
REQ-039 RST_N=0 SHALL force immediately: state=IDLE, WE=0, ADDR=0, DATA=0, FRAME_DONE=0, BUSY=0, ERR=0, all counters and edge-detect registers 0.
REQ-040 Reset asserted mid-frame SHALL abandon the frame with no FRAME_DONE.
REQ-041 After reset release, capture SHALL begin at the next VSYNC 1->0 edge with START=1.

Verification
REQ-042 Scenario nominal: START=1, one 640x480 frame -> 19200 WE pulses, ADDR 0..19199 in order, one FRAME_DONE, ERR=0.
REQ-043 Scenario encoding: pixel at col 0, row 0 with R=5'h1F, G=6'h00, B=5'h1F -> WE at ADDR 0 with DATA=8'hE3, one cycle after the READY_COLOR edge.
REQ-044 Scenario mid-frame start: START raised while VSYNC=0 and HREF active -> no WE until the next VSYNC 1->0 edge.
REQ-045 Scenario short line: line 3 carries 600 pixels -> ERR=1 after that HREF fall; frame completes; ERR clears on the next START rise.
REQ-046 Scenario held READY_COLOR: READY_COLOR held high for 10 cycles -> exactly one pixel accepted.
REQ-047 Scenario reset mid-frame: RST_N pulsed low at row 200 -> all outputs 0, no FRAME_DONE, next frame starts at ADDR 0.
